// File: rtl/i2c_slave_regfile.sv
// I2C target with a DEPTH x 8 register file, auto-incrementing pointer,
// a registered local read port and a write-notify strobe.
// state    | meaning
// IDLE     | waiting for START
// ADDR     | shifting in 7-bit address + R/W
// ADDR_ACK | holding ACK for a matched address
// PTR      | shifting in register pointer
// PTR_ACK  | holding ACK for the pointer byte
// WR_DATA  | shifting in a write byte
// WR_ACK   | holding ACK for a write byte
// RD_DATA  | driving read bits MSB first
// RD_ACK   | sampling master ACK/NACK
// IGNORE   | bus released until START or STOP
module i2c_slave_regfile #(
    parameter logic [6:0] SLV_ADDR = 7'h50,
    parameter int          DEPTH    = 16,
    parameter int          AW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe,
    output logic          busy,
    output logic          wr_valid,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          stop_det,
    input  logic [AW-1:0] loc_addr,
    output logic [7:0]    loc_rdata
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } state_t;

    state_t        state, state_n;
    logic [3:0]    bit_cnt, bit_cnt_n;
    logic [6:0]    shreg, shreg_n;
    logic          rw, rw_n;
    logic [AW-1:0] ptr, ptr_n;
    logic          sda_oe_n, busy_n, wr_valid_n, stop_det_n;
    logic [AW-1:0] wr_addr_n;
    logic [7:0]    wr_data_n;
    logic          mem_we;
    logic [7:0]    rx_byte;
    logic          rd_bit;
    logic [7:0]    mem [DEPTH];

    logic scl_s1, scl_s2, scl_d, sda_s1, sda_s2, sda_d;
    logic scl_rise, scl_fall, start_cond, stop_cond;

    // Synchronisers idle high so reset release never looks like a bus edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            {scl_s1, scl_s2, scl_d} <= 3'b111;
            {sda_s1, sda_s2, sda_d} <= 3'b111;
        end else begin
            {scl_s1, scl_s2, scl_d} <= {scl_i, scl_s1, scl_s2};
            {sda_s1, sda_s2, sda_d} <= {sda_i, sda_s1, sda_s2};
        end
    end

    assign scl_rise   = scl_s2 & ~scl_d;
    assign scl_fall   = ~scl_s2 & scl_d;
    assign start_cond = scl_s2 & scl_d & sda_d & ~sda_s2;
    assign stop_cond  = scl_s2 & scl_d & ~sda_d & sda_s2;

    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        rw_n       = rw;
        ptr_n      = ptr;
        sda_oe_n   = sda_oe;
        busy_n     = busy;
        wr_valid_n = 1'b0;
        wr_addr_n  = wr_addr;
        wr_data_n  = wr_data;
        stop_det_n = 1'b0;
        mem_we     = 1'b0;
        rx_byte    = {shreg, sda_s2};
        rd_bit     = mem[ptr][~bit_cnt[2:0]];

        if (stop_cond) begin
            state_n    = IDLE;
            sda_oe_n   = 1'b0;
            busy_n     = 1'b0;
            stop_det_n = 1'b1;
        end else if (start_cond) begin
            state_n   = ADDR;
            bit_cnt_n = 4'd0;
            sda_oe_n  = 1'b0;
        end else begin
            case (state)
                ADDR, PTR, WR_DATA: begin
                    if (scl_rise) begin
                        shreg_n   = rx_byte[6:0];
                        bit_cnt_n = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt_n = 4'd0;
                            if (state == ADDR) begin
                                if (rx_byte[7:1] == SLV_ADDR) begin
                                    state_n = ADDR_ACK;
                                    busy_n  = 1'b1;
                                    rw_n    = rx_byte[0];
                                end else begin
                                    state_n = IGNORE;
                                    busy_n  = 1'b0;
                                end
                            end else if (state == PTR) begin
                                ptr_n   = rx_byte[AW-1:0];
                                state_n = PTR_ACK;
                            end else begin
                                mem_we     = 1'b1;
                                wr_valid_n = 1'b1;
                                wr_addr_n  = ptr;
                                wr_data_n  = rx_byte;
                                ptr_n      = ptr + AW'(1);
                                state_n    = WR_ACK;
                            end
                        end
                    end
                end
                // bit_cnt 0: ACK not yet driven; 1: ACK on bus until next fall
                ADDR_ACK, PTR_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        if (bit_cnt == 4'd0) begin
                            sda_oe_n  = 1'b1;
                            bit_cnt_n = 4'd1;
                        end else begin
                            sda_oe_n  = 1'b0;
                            bit_cnt_n = 4'd0;
                            if (state != ADDR_ACK) begin
                                state_n = WR_DATA;
                            end else if (rw) begin
                                state_n   = RD_DATA;
                                sda_oe_n  = ~mem[ptr][7];
                                bit_cnt_n = 4'd1;
                            end else begin
                                state_n = PTR;
                            end
                        end
                    end
                end
                // bit_cnt counts bits already placed on the bus
                RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_oe_n  = 1'b0;
                            ptr_n     = ptr + AW'(1);
                            bit_cnt_n = 4'd0;
                            state_n   = RD_ACK;
                        end else begin
                            sda_oe_n  = ~rd_bit;
                            bit_cnt_n = bit_cnt + 4'd1;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        bit_cnt_n = 4'd0;
                        sda_oe_n  = 1'b0;
                        state_n   = sda_s2 ? IGNORE : RD_DATA;
                    end
                end
                IGNORE:  sda_oe_n = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            bit_cnt  <= 4'd0;
            shreg    <= 7'd0;
            rw       <= 1'b0;
            ptr      <= '0;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= 8'h00;
            stop_det <= 1'b0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            shreg    <= shreg_n;
            rw       <= rw_n;
            ptr      <= ptr_n;
            sda_oe   <= sda_oe_n;
            busy     <= busy_n;
            wr_valid <= wr_valid_n;
            wr_addr  <= wr_addr_n;
            wr_data  <= wr_data_n;
            stop_det <= stop_det_n;
        end
    end

    // Local read sees the pre-write value when it collides with an I2C write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
            loc_rdata <= 8'h00;
        end else begin
            if (mem_we) mem[ptr] <= rx_byte;
            loc_rdata <= mem[loc_addr];
        end
    end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: bit-banged I2C master on an
// open-drain SDA model, expected values computed by hand.
module tb_i2c_slave_regfile;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl_m, sda_m;
    logic       scl_i, sda_i;
    logic       sda_oe, busy, wr_valid, stop_det;
    logic [3:0] wr_addr, loc_addr;
    logic [7:0] wr_data, loc_rdata;

    int errors = 0;
    int checks = 0;
    int stop_cnt = 0;
    int oe_cnt = 0;
    int busy_cnt = 0;
    logic [3:0] wa_q[$];
    logic [7:0] wd_q[$];

    assign scl_i = scl_m;
    assign sda_i = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_slave_regfile dut (
        .clk       (clk),
        .reset     (reset),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .sda_oe    (sda_oe),
        .busy      (busy),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .stop_det  (stop_det),
        .loc_addr  (loc_addr),
        .loc_rdata (loc_rdata)
    );

    always @(negedge clk) begin
        if (wr_valid === 1'b1) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
        end
        if (stop_det === 1'b1) stop_cnt++;
        if (sda_oe === 1'b1) oe_cnt++;
        if (busy === 1'b1) busy_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_cycle(input logic b, output logic s);
        wait_clk(4); sda_m = b;
        wait_clk(6); scl_m = 1'b1;
        wait_clk(4); s = sda_i;
        wait_clk(4); scl_m = 1'b0;
    endtask

    task automatic i2c_start();
        if (!scl_m) begin
            wait_clk(4); sda_m = 1'b1;
            wait_clk(6); scl_m = 1'b1;
        end
        wait_clk(6); sda_m = 1'b0;
        wait_clk(6); scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clk(4); sda_m = 1'b0;
        wait_clk(6); scl_m = 1'b1;
        wait_clk(6); sda_m = 1'b1;
        wait_clk(6);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
        bit_cycle(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b1, s);
            d[i] = s;
        end
        bit_cycle(nack, s);
    endtask

    task automatic loc_read(input logic [3:0] a, output logic [7:0] d);
        loc_addr = a;
        wait_clk(1);
        d = loc_rdata;
    endtask

    task automatic check_wr(input string tag, input int idx, input logic [3:0] a, input logic [7:0] dd);
        if (idx < wa_q.size()) begin
            check({tag, "_addr"}, 32'(wa_q[idx]), 32'(a));
            check({tag, "_data"}, 32'(wd_q[idx]), 32'(dd));
        end else begin
            check({tag, "_count"}, wa_q.size(), idx + 1);
        end
    endtask

    // Transaction helper: start, address byte, expect ACK.
    task automatic addr_phase(input string tag, input logic [7:0] a);
        logic ack;
        i2c_start();
        write_byte(a, ack);
        check(tag, 32'(ack), 32'd1);
    endtask

    task automatic wr_byte_ack(input string tag, input logic [7:0] b);
        logic ack;
        write_byte(b, ack);
        check(tag, 32'(ack), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack, s;
        logic [7:0] d;
        int         s0, o0, b0;

        reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1; loc_addr = 4'd0;
        wait_clk(3);
        check("rst_sda_oe",    32'(sda_oe),    32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_wr_valid",  32'(wr_valid),  32'd0);
        check("rst_stop_det",  32'(stop_det),  32'd0);
        check("rst_wr_addr",   32'(wr_addr),   32'd0);
        check("rst_wr_data",   32'(wr_data),   32'd0);
        check("rst_loc_rdata", 32'(loc_rdata), 32'd0);
        reset = 1'b0;
        wait_clk(5);

        // write burst
        s0 = stop_cnt;
        wa_q.delete(); wd_q.delete();
        addr_phase("wb_addr_ack", 8'hA0);
        wr_byte_ack("wb_ptr_ack", 8'h03);
        wr_byte_ack("wb_d0_ack", 8'h11);
        wr_byte_ack("wb_d1_ack", 8'h22);
        i2c_stop();
        check("wb_wr_count", wa_q.size(), 2);
        check_wr("wb_wr0", 0, 4'd3, 8'h11);
        check_wr("wb_wr1", 1, 4'd4, 8'h22);
        loc_read(4'd3, d); check("wb_loc3", 32'(d), 32'h11);
        loc_read(4'd4, d); check("wb_loc4", 32'(d), 32'h22);
        check("wb_stop_det", stop_cnt - s0, 1);

        // random read with repeated START
        addr_phase("rr_addr_ack", 8'hA0);
        wr_byte_ack("rr_ptr_ack", 8'h03);
        addr_phase("rr_raddr_ack", 8'hA1);
        check("rr_busy", 32'(busy), 32'd1);
        read_byte(1'b0, d); check("rr_byte0", 32'(d), 32'h11);
        read_byte(1'b1, d); check("rr_byte1", 32'(d), 32'h22);
        wait_clk(6);
        check("rr_released", 32'(sda_oe), 32'd0);
        i2c_stop();
        wait_clk(2);
        check("rr_busy_after_p", 32'(busy), 32'd0);

        // address mismatch
        o0 = oe_cnt; b0 = busy_cnt; s0 = stop_cnt;
        wa_q.delete(); wd_q.delete();
        i2c_start();
        write_byte(8'hA2, ack); check("mm_addr_nack", 32'(ack), 32'd0);
        write_byte(8'h55, ack); check("mm_data_nack", 32'(ack), 32'd0);
        i2c_stop();
        check("mm_oe_never", oe_cnt - o0, 0);
        check("mm_busy_never", busy_cnt - b0, 0);
        check("mm_no_write", wa_q.size(), 0);
        check("mm_stop_det", stop_cnt - s0, 1);

        // pointer wrap on write and read
        wa_q.delete(); wd_q.delete();
        addr_phase("wr_addr_ack", 8'hA0);
        wr_byte_ack("wr_ptr_ack", 8'h0F);
        wr_byte_ack("wr_d0_ack", 8'hAA);
        wr_byte_ack("wr_d1_ack", 8'hBB);
        i2c_stop();
        check_wr("wrap_wr0", 0, 4'd15, 8'hAA);
        check_wr("wrap_wr1", 1, 4'd0, 8'hBB);
        loc_read(4'd15, d); check("wrap_loc15", 32'(d), 32'hAA);
        loc_read(4'd0, d);  check("wrap_loc0", 32'(d), 32'hBB);
        addr_phase("wrr_addr_ack", 8'hA0);
        wr_byte_ack("wrr_ptr_ack", 8'h0F);
        addr_phase("wrr_raddr_ack", 8'hA1);
        read_byte(1'b0, d); check("wrap_rd0", 32'(d), 32'hAA);
        read_byte(1'b1, d); check("wrap_rd1", 32'(d), 32'hBB);
        i2c_stop();

        // reset while driving a 0 read bit (reg[3]=0x11, MSB 0)
        addr_phase("rs_addr_ack", 8'hA0);
        wr_byte_ack("rs_ptr_ack", 8'h03);
        addr_phase("rs_raddr_ack", 8'hA1);
        wait_clk(6);
        check("rs_driving", 32'(sda_oe), 32'd1);
        reset = 1'b1;
        wait_clk(1);
        check("rs_oe_drop", 32'(sda_oe), 32'd0);
        wait_clk(2);
        reset = 1'b0;
        wait_clk(1);
        check("rs_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 16; i++) begin
            loc_read(4'(i), d);
            check($sformatf("rs_clear%0d", i), 32'(d), 32'h00);
        end
        wait_clk(4); scl_m = 1'b1;
        wait_clk(10);
        wa_q.delete(); wd_q.delete();
        addr_phase("rs2_addr_ack", 8'hA0);
        wr_byte_ack("rs2_ptr_ack", 8'h05);
        wr_byte_ack("rs2_d0_ack", 8'h5A);
        i2c_stop();
        check_wr("rs2_wr0", 0, 4'd5, 8'h5A);
        loc_read(4'd5, d); check("rs2_loc5", 32'(d), 32'h5A);

        // repeated START after 4 data bits of a write
        addr_phase("sr_pre_addr", 8'hA0);
        wr_byte_ack("sr_pre_ptr", 8'h07);
        wr_byte_ack("sr_pre_d0", 8'h3C);
        i2c_stop();
        wa_q.delete(); wd_q.delete();
        addr_phase("sr_addr_ack", 8'hA0);
        wr_byte_ack("sr_ptr_ack", 8'h07);
        bit_cycle(1'b1, s);
        bit_cycle(1'b0, s);
        bit_cycle(1'b1, s);
        bit_cycle(1'b0, s);
        addr_phase("sr_raddr_ack", 8'hA1);
        read_byte(1'b1, d); check("sr_ptr_kept", 32'(d), 32'h3C);
        i2c_stop();
        check("sr_no_write", wa_q.size(), 0);
        loc_read(4'd7, d); check("sr_loc7", 32'(d), 32'h3C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
